// File: rtl/fuzz_stim_pkg.sv
// Shared definitions for the fuzz stimulus generator: LCG constants, FSM
// state encoding and the words-per-vector helper.
package fuzz_stim_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC = 32'h0000_3039;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Number of 32-bit LCG words needed to cover a vector of vec_w bits.
  function automatic int unsigned calc_nw(input int unsigned vec_w);
    return (vec_w + WORD_W - 1) / WORD_W;
  endfunction

endpackage

// File: rtl/fuzz_stim_gen_if.sv
// Stimulus delivery bus between the generator and the consumer.
//   vec_o       : assembled stimulus vector
//   vec_valid_o : vec_o holds a complete vector
//   vec_ready_i : consumer accepts vec_o this cycle
//   vec_idx_o   : 0-based index of the vector currently presented
interface fuzz_stim_gen_if #(
  parameter int unsigned VEC_W = 262
);
  logic [VEC_W-1:0] vec_o;
  logic             vec_valid_o;
  logic             vec_ready_i;
  logic [31:0]      vec_idx_o;

  modport master (output vec_o, output vec_valid_o, output vec_idx_o, input vec_ready_i);
  modport slave  (input vec_o, input vec_valid_o, input vec_idx_o, output vec_ready_i);
endinterface

// File: rtl/fuzz_lcg32.sv
// One step of the 32-bit linear congruential generator.
//   s_i      : current LCG state
//   s_next_c : s_i * LCG_MUL + LCG_INC, modulo 2^32 (combinational)
module fuzz_lcg32
  import fuzz_stim_pkg::*;
(
  input  logic [31:0] s_i,
  output logic [31:0] s_next_c
);

  assign s_next_c = s_i * LCG_MUL + LCG_INC;

endmodule

// File: rtl/fuzz_stim_gen.sv
// Pseudo-random stimulus generator: fills a VEC_W-bit vector one LCG word
// per cycle, presents it with a valid/ready handshake and repeats for the
// requested number of vectors.
//   clk, rst            : clock, synchronous active-high reset
//   start_i             : run request (ignored while busy_o)
//   seed_i, num_vec_i   : run seed (0 selects DEF_SEED) and vector count
//   bus                 : vector / valid / ready / index (master side)
//   busy_o, done_o      : run in progress, run complete
module fuzz_stim_gen
  import fuzz_stim_pkg::*;
#(
  parameter int unsigned VEC_W    = 262,
  parameter logic [31:0] DEF_SEED = 32'd2812738018
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [31:0]     seed_i,
  input  logic [31:0]     num_vec_i,
  fuzz_stim_gen_if.master bus,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned NW     = calc_nw(VEC_W);
  localparam int unsigned LAST_W = VEC_W - WORD_W * (NW - 1);
  localparam int unsigned K_W    = (NW > 1) ? $clog2(NW) : 1;

  state_e           state_q;
  logic [31:0]      s_q;
  logic [31:0]      count_q;
  logic [31:0]      idx_q;
  logic [K_W-1:0]   k_q;
  logic [VEC_W-1:0] vec_q;
  logic             valid_q;

  logic [31:0]      s_next_c;
  logic [VEC_W-1:0] vec_fill_c;

  fuzz_lcg32 u_lcg (
    .s_i      (s_q),
    .s_next_c (s_next_c)
  );

  // Vector with word k_q replaced by the next LCG value; last word truncated.
  for (genvar w = 0; w < NW; w++) begin : g_word
    localparam int unsigned LO   = w * WORD_W;
    localparam int unsigned BITS = (w == NW - 1) ? LAST_W : WORD_W;
    assign vec_fill_c[LO +: BITS] = (k_q == K_W'(w)) ? s_next_c[BITS-1:0]
                                                     : vec_q[LO +: BITS];
  end

  assign bus.vec_o       = vec_q;
  assign bus.vec_valid_o = valid_q;
  assign bus.vec_idx_o   = idx_q;

  // Run control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= DEF_SEED;
      count_q <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            s_q     <= (seed_i == 32'd0) ? DEF_SEED : seed_i;
            count_q <= num_vec_i;
            idx_q   <= '0;
            k_q     <= '0;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          // An empty run spends exactly one FILL cycle and never presents.
          if (count_q == 32'd0) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            s_q   <= s_next_c;
            vec_q <= vec_fill_c;
            if (k_q == K_W'(NW - 1)) begin
              k_q     <= '0;
              valid_q <= 1'b1;
              state_q <= ST_PRESENT;
            end else begin
              k_q <= k_q + K_W'(1);
            end
          end
        end
        ST_PRESENT: begin
          if (valid_q && bus.vec_ready_i) begin
            valid_q <= 1'b0;
            idx_q   <= idx_q + 32'd1;
            if ((idx_q + 32'd1) < count_q) begin
              state_q <= ST_FILL;
            end else begin
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_stim_gen.sv
// Self-checking bench for fuzz_stim_gen using an expected-vector scoreboard.
module tb_fuzz_stim_gen;

  localparam int unsigned VW       = 262;
  localparam int unsigned NW       = 9;
  localparam logic [31:0] DEF_SEED = 32'd2812738018;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start64;
  logic [31:0] seed, seed64;
  logic [31:0] num, num64;
  logic        ready, ready64;
  logic        busy, busy64;
  logic        done, done64;

  int checks = 0;
  int errors = 0;

  logic [31:0]   model_s;
  logic [VW-1:0] exp_vec_q[$];
  int            exp_idx_q[$];

  fuzz_stim_gen_if #(.VEC_W(VW)) bus ();
  fuzz_stim_gen_if #(.VEC_W(64)) bus64 ();

  assign bus.vec_ready_i   = ready;
  assign bus64.vec_ready_i = ready64;

  fuzz_stim_gen #(.VEC_W(VW), .DEF_SEED(DEF_SEED)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .seed_i    (seed),
    .num_vec_i (num),
    .bus       (bus),
    .busy_o    (busy),
    .done_o    (done)
  );

  fuzz_stim_gen #(.VEC_W(64), .DEF_SEED(32'd0)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start64),
    .seed_i    (seed64),
    .num_vec_i (num64),
    .bus       (bus64),
    .busy_o    (busy64),
    .done_o    (done64)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h00003039;
  endfunction

  function automatic logic [VW-1:0] model_next_vec();
    logic [NW*32-1:0] full;
    full = '0;
    for (int w = 0; w < NW; w++) begin
      model_s = lcg(model_s);
      full[w*32 +: 32] = model_s;
    end
    return full[VW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!bus.vec_valid_o && n < 64) begin
      tick();
      n++;
    end
    ok = bus.vec_valid_o;
  endtask

  // Pulse start on the main DUT and push the whole expected run.
  task automatic start_run(input logic [31:0] s, input int n);
    start = 1'b1;
    seed  = s;
    num   = 32'(n);
    tick();
    start = 1'b0;
    model_s = (s == 32'd0) ? DEF_SEED : s;
    for (int i = 0; i < n; i++) begin
      exp_vec_q.push_back(model_next_vec());
      exp_idx_q.push_back(i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.vec_o !== '0) begin errors++; $display("FAIL rst_vec: got %h exp 0", bus.vec_o); end
    checks++; if (bus.vec_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", bus.vec_valid_o); end
    checks++; if (bus.vec_idx_o !== 32'd0) begin errors++; $display("FAIL rst_idx: got %0d exp 0", bus.vec_idx_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream(input logic [31:0] s, input int n);
    int cyc;
    bit ok;
    logic [VW-1:0] ev;
    int ei;
    ready = 1'b1;
    start_run(s, n);
    cyc = 0;
    while (!bus.vec_valid_o && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != NW) begin errors++; $display("FAIL stream_latency seed=%0d: got %0d exp %0d", s, cyc, NW); end
    for (int i = 0; i < n; i++) begin
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stream_timeout seed=%0d vec %0d: got valid 0 exp 1", s, i); break; end
      ev = exp_vec_q.pop_front();
      ei = exp_idx_q.pop_front();
      checks++; if (bus.vec_o !== ev) begin errors++; $display("FAIL stream_vec seed=%0d idx %0d: got %h exp %h", s, ei, bus.vec_o, ev); end
      checks++; if (bus.vec_idx_o !== 32'(ei)) begin errors++; $display("FAIL stream_idx seed=%0d: got %0d exp %0d", s, bus.vec_idx_o, ei); end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stream_end seed=%0d: got done=%b busy=%b exp done=1 busy=0", s, done, busy); end
    checks++; if (bus.vec_idx_o !== 32'(n)) begin errors++; $display("FAIL stream_final_idx seed=%0d: got %0d exp %0d", s, bus.vec_idx_o, n); end
    exp_vec_q.delete();
    exp_idx_q.delete();
  endtask

  task automatic test_seed_zero64();
    int n;
    ready64 = 1'b1;
    seed64  = 32'd0;
    num64   = 32'd1;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    n = 0;
    while (!bus64.vec_valid_o && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL seed0_64_latency: got %0d exp 2", n); end
    checks++; if (bus64.vec_o !== 64'hD3DC167E_00003039) begin errors++; $display("FAIL seed0_64_vec: got %h exp d3dc167e00003039", bus64.vec_o); end
    tick();
    checks++; if (done64 !== 1'b1 || bus64.vec_valid_o !== 1'b0) begin errors++; $display("FAIL seed0_64_done: got done=%b valid=%b exp 1/0", done64, bus64.vec_valid_o); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [VW-1:0] ev, held_vec;
    int ei;
    ready = 1'b0;
    start_run(32'd5, 3);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got valid 0 exp 1"); end
    ev = exp_vec_q.pop_front();
    ei = exp_idx_q.pop_front();
    checks++; if (bus.vec_o !== ev) begin errors++; $display("FAIL bp_vec0: got %h exp %h", bus.vec_o, ev); end
    held_vec = ev;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.vec_o !== held_vec || bus.vec_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_vec c%0d: got %h valid=%b exp %h valid=1", c, bus.vec_o, bus.vec_valid_o, held_vec); end
      checks++; if (bus.vec_idx_o !== 32'(ei)) begin errors++; $display("FAIL bp_hold_idx c%0d: got %0d exp %0d", c, bus.vec_idx_o, ei); end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++; if (bus.vec_idx_o !== 32'd1 || bus.vec_valid_o !== 1'b0) begin errors++; $display("FAIL bp_accept: got idx=%0d valid=%b exp idx=1 valid=0", bus.vec_idx_o, bus.vec_valid_o); end
    for (int i = 1; i < 3; i++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_timeout%0d: got valid 0 exp 1", i); end
      ev = exp_vec_q.pop_front();
      ei = exp_idx_q.pop_front();
      checks++; if (bus.vec_o !== ev || bus.vec_idx_o !== 32'(ei)) begin errors++; $display("FAIL bp_vec%0d: got idx %0d %h exp idx %0d %h", i, bus.vec_idx_o, bus.vec_o, ei, ev); end
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b exp 1", done); end
  endtask

  task automatic test_zero_count();
    bit seen;
    ready = 1'b1;
    start_run(32'd7, 0);
    checks++; if (done !== 1'b0 || bus.vec_valid_o !== 1'b0) begin errors++; $display("FAIL zero_early: got done=%b valid=%b exp 0/0", done, bus.vec_valid_o); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b busy=%b exp 1/0", done, busy); end
    seen = bus.vec_valid_o;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen |= bus.vec_valid_o;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b exp 0", seen); end
  endtask

  task automatic test_single();
    bit ok, seen;
    logic [VW-1:0] ev;
    int ei;
    ready = 1'b0;
    start_run(32'd9, 1);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got valid 0 exp 1"); end
    ev = exp_vec_q.pop_front();
    ei = exp_idx_q.pop_front();
    checks++; if (bus.vec_o !== ev || bus.vec_idx_o !== 32'(ei)) begin errors++; $display("FAIL single_vec: got idx %0d %h exp idx %0d %h", bus.vec_idx_o, bus.vec_o, ei, ev); end
    ready = 1'b1;
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.vec_idx_o !== 32'd1) begin errors++; $display("FAIL single_done: got done=%b busy=%b idx=%0d exp 1/0/1", done, busy, bus.vec_idx_o); end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen |= bus.vec_valid_o;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL single_extra_valid: got %b exp 0", seen); end
    ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit ok;
    logic [VW-1:0] ev;
    int ei;
    ready = 1'b1;
    start_run(32'd11, 2);
    tick();
    tick();
    tick();
    start = 1'b1;
    seed  = 32'd99;
    num   = 32'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ign_timeout%0d: got valid 0 exp 1", i); end
      ev = exp_vec_q.pop_front();
      ei = exp_idx_q.pop_front();
      checks++; if (bus.vec_o !== ev || bus.vec_idx_o !== 32'(ei)) begin errors++; $display("FAIL ign_vec%0d: got idx %0d %h exp idx %0d %h", i, bus.vec_idx_o, bus.vec_o, ei, ev); end
      tick();
    end
    checks++; if (done !== 1'b1 || bus.vec_idx_o !== 32'd2) begin errors++; $display("FAIL ign_done: got done=%b idx=%0d exp 1/2", done, bus.vec_idx_o); end
    start_run(32'd11, 1);
    checks++; if (bus.vec_idx_o !== 32'd0 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_state: got idx=%0d done=%b busy=%b exp 0/0/1", bus.vec_idx_o, done, busy); end
    wait_valid(ok);
    ev = exp_vec_q.pop_front();
    ei = exp_idx_q.pop_front();
    checks++; if (!ok || bus.vec_o !== ev || bus.vec_idx_o !== 32'(ei)) begin errors++; $display("FAIL restart_vec: got valid=%b idx %0d %h exp idx %0d %h", ok, bus.vec_idx_o, bus.vec_o, ei, ev); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [VW-1:0] ev;
    int ei;
    ready = 1'b1;
    start_run(32'd13, 6);
    for (int i = 0; i < 4; i++) begin
      wait_valid(ok);
      ev = exp_vec_q.pop_front();
      ei = exp_idx_q.pop_front();
      checks++; if (!ok || bus.vec_o !== ev || bus.vec_idx_o !== 32'(ei)) begin errors++; $display("FAIL rmid_vec%0d: got valid=%b idx %0d %h exp idx %0d %h", i, ok, bus.vec_idx_o, bus.vec_o, ei, ev); end
      if (i < 3) tick();
      else ready = 1'b0;
    end
    rst = 1'b1;
    tick();
    checks++; if (bus.vec_o !== '0 || bus.vec_valid_o !== 1'b0 || bus.vec_idx_o !== 32'd0) begin errors++; $display("FAIL rmid_bus: got valid=%b idx=%0d vec=%h exp 0/0/0", bus.vec_valid_o, bus.vec_idx_o, bus.vec_o); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_flags: got busy=%b done=%b exp 0/0", busy, done); end
    rst = 1'b0;
    tick();
    checks++; if (bus.vec_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_post_valid: got %b exp 0", bus.vec_valid_o); end
    exp_vec_q.delete();
    exp_idx_q.delete();
    start_run(32'd13, 1);
    wait_valid(ok);
    ev = exp_vec_q.pop_front();
    ei = exp_idx_q.pop_front();
    checks++; if (!ok || bus.vec_o !== ev || bus.vec_idx_o !== 32'(ei)) begin errors++; $display("FAIL rmid_replay: got valid=%b idx %0d %h exp idx %0d %h", ok, bus.vec_idx_o, bus.vec_o, ei, ev); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    seed    = '0;
    num     = '0;
    ready   = 1'b0;
    start64 = 1'b0;
    seed64  = '0;
    num64   = '0;
    ready64 = 1'b0;
    model_s = DEF_SEED;
    test_reset();
    test_stream(32'd1, 300);
    test_stream(32'd0, 300);
    test_seed_zero64();
    test_backpressure();
    test_zero_count();
    test_single();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
